// File: rtl/shift_reg_serdes_if.sv
// shift_reg_serdes_if: parallel write/read handshake and serial bit lanes of the serdes core.
interface shift_reg_serdes_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] i_wr_data;
    logic             i_wr_valid;
    logic             o_wr_ready;
    logic             i_shift_en;
    logic             i_ser_in;
    logic             o_ser_out;
    logic             o_busy;
    logic             o_last;
    logic [WIDTH-1:0] o_rd_data;
    logic             o_rd_valid;
    modport master (
        output i_wr_data, i_wr_valid, i_shift_en, i_ser_in,
        input  o_wr_ready, o_ser_out, o_busy, o_last, o_rd_data, o_rd_valid
    );
    modport slave (
        input  i_wr_data, i_wr_valid, i_shift_en, i_ser_in,
        output o_wr_ready, o_ser_out, o_busy, o_last, o_rd_data, o_rd_valid
    );
endinterface

// File: rtl/shift_reg_serdes.sv
// shift_reg_serdes: full-duplex serialiser/deserialiser sharing one shift register for tx and rx.
module shift_reg_serdes #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input logic                clk,
    input logic                rst_n,
    shift_reg_serdes_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;
    logic [WIDTH-1:0] sr, sr_next;
    logic [CW-1:0]    cnt;
    logic [0:0]       state;
    logic             shift, fin, load;
    always_comb begin
        sr_next        = (MSB_FIRST != 0) ? {sr[WIDTH-2:0], bus.i_ser_in} : {bus.i_ser_in, sr[WIDTH-1:1]};
        bus.o_ser_out  = (MSB_FIRST != 0) ? sr[WIDTH-1] : sr[0];
        bus.o_busy     = state == SHIFT;
        bus.o_last     = bus.o_busy && cnt == CW'(WIDTH - 1);
        shift          = bus.o_busy & bus.i_shift_en;
        fin            = bus.o_last & bus.i_shift_en;
        // ready during the final enabled tick lets the next frame start with no idle gap
        bus.o_wr_ready = !bus.o_busy | fin;
        load           = bus.i_wr_valid & bus.o_wr_ready;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr             <= '0;
            cnt            <= '0;
            state          <= IDLE;
            bus.o_rd_data  <= '0;
            bus.o_rd_valid <= 1'b0;
        end else begin
            bus.o_rd_valid <= fin;
            if (fin) bus.o_rd_data <= sr_next;
            if (load) begin
                sr    <= bus.i_wr_data;
                cnt   <= '0;
                state <= SHIFT;
            end else if (shift) begin
                sr  <= sr_next;
                cnt <= cnt + 1'b1;
                if (fin) state <= IDLE;
            end
        end
    end
endmodule
